// File: rtl/cplx_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cplx_alu_pipe
// Brief    : Two-stage pipelined complex ALU (ADD/SUB/MUL/ACC) with valid/ready
//            flow control and overflow flag. CPLX_ALU_SAT_EN selects saturation.
// Revision : 1.0 - initial release
// ============================================================================
module cplx_alu_pipe #(
    parameter int PART_LEN  = 8,
    parameter int FRAC_BITS = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            op_i,
    input  logic [2*PART_LEN-1:0] a_i,
    input  logic [2*PART_LEN-1:0] b_i,
    input  logic                  acc_clr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2*PART_LEN-1:0] res_o,
    output logic                  ovf_o
);
    localparam int         c_W      = 2 * PART_LEN;
    localparam int         c_XW     = 2 * PART_LEN + 1;
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_ACC = 2'b11;

    function automatic logic [c_XW-1:0] sext_s(input logic [PART_LEN:0] v);
        return {{(c_XW-PART_LEN-1){v[PART_LEN]}}, v};
    endfunction

    function automatic logic [c_XW-1:0] sext_p(input logic [c_W-1:0] v);
        return {v[c_W-1], v};
    endfunction

    function automatic logic [c_W-1:0] sext_h(input logic [PART_LEN-1:0] v);
        return {{PART_LEN{v[PART_LEN-1]}}, v};
    endfunction

    function automatic logic [PART_LEN:0] add_h(input logic [PART_LEN-1:0] x,
                                                input logic [PART_LEN-1:0] y,
                                                input logic                sub);
        logic [PART_LEN:0] xe;
        logic [PART_LEN:0] ye;
        xe = {x[PART_LEN-1], x};
        ye = {y[PART_LEN-1], y};
        return sub ? (xe - ye) : (xe + ye);
    endfunction

    // Returns {ovf, part}; in range iff all bits above the part's sign bit match it.
    function automatic logic [PART_LEN:0] fin_part(input logic [c_XW-1:0] x);
        logic [PART_LEN+1:0] hi;
        logic                ov;
        logic [PART_LEN-1:0] v;
        hi = x[c_XW-1:PART_LEN-1];
        ov = !((&hi) || !(|hi));
`ifdef CPLX_ALU_SAT_EN
        if (ov)
            v = x[c_XW-1] ? {1'b1, {(PART_LEN-1){1'b0}}} : {1'b0, {(PART_LEN-1){1'b1}}};
        else
            v = x[PART_LEN-1:0];
`else
        v = x[PART_LEN-1:0];
`endif
        return {ov, v};
    endfunction

    logic [PART_LEN-1:0] w_ar, w_ai, w_br, w_bi;
    logic                w_stall, w_adv;
    logic [c_W-1:0]      w_p_rr, w_p_ii, w_p_ri, w_p_ir;

    logic                s1_valid_q;
    logic [1:0]          s1_op_q;
    logic [c_W-1:0]      s1_a_q;
    logic [PART_LEN:0]   s1_sre_q, s1_sim_q;
    logic [c_W-1:0]      s1_prr_q, s1_pii_q, s1_pri_q, s1_pir_q;

    logic                out_valid_q, ovf_q, ovf_d;
    logic [c_W-1:0]      res_q, res_d, acc_q, acc_d;
    logic [c_W-1:0]      w_acc_base;
    logic [c_XW-1:0]     w_mre, w_mim, w_xre, w_xim;
    logic [PART_LEN:0]   w_fre, w_fim;

    assign w_ar = a_i[c_W-1:PART_LEN];
    assign w_ai = a_i[PART_LEN-1:0];
    assign w_br = b_i[c_W-1:PART_LEN];
    assign w_bi = b_i[PART_LEN-1:0];

    assign w_stall    = out_valid_q && !out_ready_i;
    assign w_adv      = !w_stall;
    assign in_ready_o = w_adv;

    assign w_p_rr = $signed(sext_h(w_ar)) * $signed(sext_h(w_br));
    assign w_p_ii = $signed(sext_h(w_ai)) * $signed(sext_h(w_bi));
    assign w_p_ri = $signed(sext_h(w_ar)) * $signed(sext_h(w_bi));
    assign w_p_ir = $signed(sext_h(w_ai)) * $signed(sext_h(w_br));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_sre_q   <= '0;
            s1_sim_q   <= '0;
            s1_prr_q   <= '0;
            s1_pii_q   <= '0;
            s1_pri_q   <= '0;
            s1_pir_q   <= '0;
        end else if (w_adv) begin
            s1_valid_q <= in_valid_i;
            s1_op_q    <= op_i;
            s1_a_q     <= a_i;
            s1_sre_q   <= add_h(w_ar, w_br, op_i == c_OP_SUB);
            s1_sim_q   <= add_h(w_ai, w_bi, op_i == c_OP_SUB);
            s1_prr_q   <= w_p_rr;
            s1_pii_q   <= w_p_ii;
            s1_pri_q   <= w_p_ri;
            s1_pir_q   <= w_p_ir;
        end
    end

    assign w_mre = sext_p(s1_prr_q) - sext_p(s1_pii_q);
    assign w_mim = sext_p(s1_pri_q) + sext_p(s1_pir_q);

    // A clear in the same cycle as an ACC commit is seen by that commit.
    always_comb begin
        w_acc_base = acc_clr_i ? '0 : acc_q;
        w_xre      = '0;
        w_xim      = '0;
        case (s1_op_q)
            c_OP_ADD, c_OP_SUB: begin
                w_xre = sext_s(s1_sre_q);
                w_xim = sext_s(s1_sim_q);
            end
            c_OP_MUL: begin
                w_xre = $signed(w_mre) >>> FRAC_BITS;
                w_xim = $signed(w_mim) >>> FRAC_BITS;
            end
            default: begin
                w_xre = sext_s(add_h(w_acc_base[c_W-1:PART_LEN], s1_a_q[c_W-1:PART_LEN], 1'b0));
                w_xim = sext_s(add_h(w_acc_base[PART_LEN-1:0], s1_a_q[PART_LEN-1:0], 1'b0));
            end
        endcase
        w_fre = fin_part(w_xre);
        w_fim = fin_part(w_xim);
        res_d = {w_fre[PART_LEN-1:0], w_fim[PART_LEN-1:0]};
        ovf_d = w_fre[PART_LEN] | w_fim[PART_LEN];
        acc_d = w_acc_base;
        if (w_adv && s1_valid_q && (s1_op_q == c_OP_ACC))
            acc_d = res_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            if (w_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cplx_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cplx_alu_pipe
// Brief    : Scoreboard bench for cplx_alu_pipe (FRAC_BITS=0 and FRAC_BITS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cplx_alu_pipe;
    logic        clk = 1'b0;
    logic        rstn, in_valid, out_ready, acc_clr;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        in_ready, in_ready2;
    logic        out_valid1, out_valid2, ovf1, ovf2;
    logic [15:0] res1, res2;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          bp_rand = 1'b0;
    int          acc_re, acc_im;
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    logic [15:0] snap;

    always #5 clk = ~clk;

    cplx_alu_pipe #(.PART_LEN(8), .FRAC_BITS(0)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .a_i(a), .b_i(b), .acc_clr_i(acc_clr),
        .out_valid_o(out_valid1), .out_ready_i(out_ready), .res_o(res1), .ovf_o(ovf1)
    );

    cplx_alu_pipe #(.PART_LEN(8), .FRAC_BITS(2)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .op_i(op), .a_i(a), .b_i(b), .acc_clr_i(acc_clr),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .res_o(res2), .ovf_o(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] cx(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return {r[7:0], i[7:0]};
    endfunction

    // {ovf, value} of one exact part result
    function automatic logic [8:0] fin(input int x);
        logic [31:0] xb;
        logic [8:0]  r;
        xb   = x;
        r[8] = (x < -128) || (x > 127);
`ifdef CPLX_ALU_SAT_EN
        if (x > 127)       r[7:0] = 8'h7f;
        else if (x < -128) r[7:0] = 8'h80;
        else               r[7:0] = xb[7:0];
`else
        r[7:0] = xb[7:0];
`endif
        return r;
    endfunction

    task automatic push_expected(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
        int ar, ai, br, bi, xr, xi, f;
        logic [8:0] fr, fi;
        logic [8:0] fr0, fi0;
        ar = sx(va[15:8]); ai = sx(va[7:0]);
        br = sx(vb[15:8]); bi = sx(vb[7:0]);
        fr0 = '0; fi0 = '0;
        for (int k = 0; k < 2; k++) begin
            f = (k == 0) ? 0 : 2;
            case (o)
                2'b00: begin xr = ar + br; xi = ai + bi; end
                2'b01: begin xr = ar - br; xi = ai - bi; end
                2'b10: begin xr = (ar*br - ai*bi) >>> f; xi = (ar*bi + ai*br) >>> f; end
                default: begin xr = acc_re + ar; xi = acc_im + ai; end
            endcase
            fr = fin(xr);
            fi = fin(xi);
            if (k == 0) begin
                q1.push_back({fr[8] | fi[8], fr[7:0], fi[7:0]});
                fr0 = fr; fi0 = fi;
            end else begin
                q2.push_back({fr[8] | fi[8], fr[7:0], fi[7:0]});
            end
        end
        if (o == 2'b11) begin
            acc_re = sx(fr0[7:0]);
            acc_im = sx(fi0[7:0]);
        end
    endtask

    task automatic send(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
        int guard;
        guard = 0;
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
        end else begin
            push_expected(o, va, vb);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        logic [16:0] e;
        @(negedge clk);
        #2;
        if (rstn && out_valid1 && out_ready) begin
            if (q1.size() == 0) check("unexpected_out1", 32'(out_valid1), 32'd0);
            else begin
                e = q1.pop_front();
                check("res_f0", {15'd0, ovf1, res1}, {15'd0, e});
            end
        end
        if (rstn && out_valid2 && out_ready) begin
            if (q2.size() == 0) check("unexpected_out2", 32'(out_valid2), 32'd0);
            else begin
                e = q2.pop_front();
                check("res_f2", {15'd0, ovf2, res2}, {15'd0, e});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        acc_clr = 1'b0; out_ready = 1'b1; acc_re = 0; acc_im = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid1), 32'd0);
        check("rst_res", 32'(res1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send(2'b00, cx(3, 4), cx(1, -2));
        send(2'b01, cx(3, 4), cx(1, -2));
        send(2'b10, cx(3, 2), cx(1, 4));
        send(2'b10, cx(8, 0), cx(8, 4));
        send(2'b00, cx(100, 0), cx(100, 0));
        idle(4);

        @(negedge clk) acc_clr = 1'b1;
        @(negedge clk) acc_clr = 1'b0;
        acc_re = 0; acc_im = 0;
        send(2'b11, cx(1, 1), cx(9, 9));
        send(2'b11, cx(2, -3), cx(0, 0));
        send(2'b11, cx(5, 0), cx(0, 0));
        acc_re = 0; acc_im = 0;
        send(2'b11, cx(4, 4), cx(1, 1));
        @(negedge clk) acc_clr = 1'b1;
        @(negedge clk) acc_clr = 1'b0;
        idle(4);

        // Backpressure: hold out_ready low while four ADDs are offered.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(2'b00, cx(i*10 + 1, -i), cx(2, 3));
            end
            begin
                repeat (3) @(negedge clk);
                #3;
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_valid", 32'(out_valid1), 32'd1);
                snap = res1;
                @(negedge clk);
                #3 check("bp_res_stable1", 32'(res1), 32'(snap));
                @(negedge clk);
                check("bp_res_stable2", 32'(res1), 32'(snap));
                check("bp_in_ready_hold", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_drained", 32'(q1.size()), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(2'b00, cx(1, 2), cx(3, 4));
        send(2'b01, cx(5, 5), cx(1, 1));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid1), 32'd0);
        check("arst_res", 32'(res1), 32'd0);
        check("arst_out_valid2", 32'(out_valid2), 32'd0);
        q1.delete(); q2.delete();
        acc_re = 0; acc_im = 0;
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        send(2'b00, cx(10, 20), cx(1, 1));
        @(negedge clk);
        #1 check("lat_cycle1", 32'(out_valid1), 32'd0);
        @(negedge clk);
        #1 check("lat_cycle2", 32'(out_valid1), 32'd1);
        send(2'b11, cx(7, -1), cx(0, 0));
        idle(4);

        bp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        check("final_drain1", 32'(q1.size()), 32'd0);
        check("final_drain2", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cplx_alu_pipe.md
Name: cplx_alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational complex add/sub unit.
- Operands are packed as {real, imag}; each part is a two's-complement signed field of PART_LEN bits.
- Adds three things the old unit lacks: complex multiply, a running complex accumulator, and valid/ready flow control with an overflow flag.
- Sits between the sample source and the complex datapath consumers.

Parameters:
- PART_LEN, 8, width of each real/imag part in bits (>= 4).
- FRAC_BITS, 0, arithmetic right shift applied to MUL products before truncating to PART_LEN (0 <= FRAC_BITS < PART_LEN).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 ACC.
- a  in  2*PART_LEN  operand A {re, im}.
- b  in  2*PART_LEN  operand B {re, im}; ignored for ACC.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- res  out  2*PART_LEN  result {re, im}.
- ovf  out  1  result overflowed PART_LEN in either part; qualified by out_valid.

Behaviour:
- Reset (rstn low, async): stage valids, out_valid, res, ovf and acc all go to 0. in_ready is 1 once reset deasserts. An in-flight transaction is dropped, never emitted.
- Input handshake: input accepted when in_valid && in_ready.
- Output handshake: output consumed when out_valid && out_ready.
- Pipeline: two register stages, latency exactly 2 cycles from acceptance to out_valid when not stalled. Throughput is 1 per cycle.
  - S1 registers the op, the A operand, the raw sums/differences (PART_LEN+1 bits) and the four products (2*PART_LEN bits).
  - S2 computes the final value and registers res/ovf.
- Stall: stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, S1 and S2 hold and res/ovf stay stable.
  - Bubbles are not collapsed.
- ADD/SUB: component-wise a ± b, computed at PART_LEN+1 bits, result = low PART_LEN bits.
- MUL:
  - re = ar*br - ai*bi and im = ar*bi + ai*br, computed at 2*PART_LEN+1 bits.
  - Arithmetic shift right by FRAC_BITS (truncate toward -inf), then take the low PART_LEN bits.
- ACC:
  - acc_next = acc + a, component-wise at PART_LEN+1 bits then truncated; res = acc_next.
  - acc updates only when the ACC transaction advances into S2.
- ovf: 1 when the exact result of either part lies outside [-2^(PART_LEN-1), 2^(PART_LEN-1)-1].
- acc_clr:
  - Takes effect on the clock edge where it is high, independent of the handshake.
  - If it coincides with an ACC commit into S2, the clear applies first, so acc <= a and res = a.
  - If an ACC transaction is sitting in S1 when acc_clr is high, that transaction sees the cleared acc.
- The op is captured per transaction, so mixed ops back-to-back are legal.
- in_valid low produces bubbles; out_valid follows accordingly.

Optional Feature:
- Macro CPLX_ALU_SAT_EN.
- Defined: every overflowing part saturates to 2^(PART_LEN-1)-1 or -2^(PART_LEN-1) according to the sign of the exact result. The accumulator stores the saturated value. ovf still flags the event.
- Undefined: results wrap (two's-complement truncation) and ovf is informational only.

Test Plan:
All cases use PART_LEN=8, FRAC_BITS=0.
- ADD: a=(3,4), b=(1,-2), op=00 -> 2 cycles later res=(4,2), ovf=0. SUB with the same operands -> res=(2,6).
- MUL: a=(3,2), b=(1,4) -> res=(-5,14). With FRAC_BITS=2: a=(8,0), b=(8,4) -> res=(16,8).
- Overflow: ADD a=(100,0), b=(100,0) -> wrap build gives res=(-56,0), ovf=1; CPLX_ALU_SAT_EN build gives res=(127,0), ovf=1.
- ACC:
  - acc_clr pulse, then ACC a=(1,1), (2,-3), (5,0) back-to-back -> res=(1,1), (3,-2), (8,-2).
  - acc_clr high in the same cycle the next ACC a=(4,4) commits to S2 -> res=(4,4).
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming 4 ADDs -> in_ready drops, res stays stable.
  - Release -> all 4 results arrive in order, none lost or duplicated.
- Reset mid-operation: assert rstn=0 with S1 and S2 full -> out_valid=0 and res=0 immediately (async). After release the first new transaction emerges after exactly 2 cycles, and acc=0.
